led_mode_sequencer: RTL and testbench

Controller between the fake_fpga bridge's button bus and its LED bus. It debounces the 8 buttons returned by the bridge and runs a mode FSM selected by button presses. A prescaled tick sequences the LED pattern (count, rotate, XOR-chain), which is driven back into the bridge's LED input.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_mode_sequencer_btn_debounce.sv | 51 +++++
 rtl/led_mode_sequencer.sv | 109 ++++++++++
 tb/tb_led_mode_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer.
package led_seq_pkg;

  localparam int unsigned LED_W     = 8;
  localparam int unsigned BTN_NEXT  = 0;
  localparam int unsigned BTN_PAUSE = 1;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_PAUSE = 2'd3
  } mode_e;

  // Cycles COUNT -> SHIFT -> XOR -> COUNT; PAUSE maps to itself.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_COUNT: next_mode = MODE_SHIFT;
      MODE_SHIFT: next_mode = MODE_XOR;
      MODE_XOR:   next_mode = MODE_COUNT;
      default:    next_mode = m;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Single-bit debouncer: db follows raw after DEBOUNCE consecutive differing
// cycles; press pulses for one cycle on the edge after each db rise.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic          press_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (raw_i == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = raw_i;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED pattern sequencer (COUNT/SHIFT/XOR/PAUSE) with prescaled steps.
// Define LED_SEQ_SYNC_EN to add a 2-flop synchronizer ahead of the debouncers.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] buttons,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [LED_W-1:0] raw;
  logic [LED_W-1:0] db;
  logic [LED_W-1:0] press;

`ifdef LED_SEQ_SYNC_EN
  logic [LED_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;
`else
  assign raw = buttons;
`endif

  for (genvar i = 0; i < LED_W; i++) begin : g_db
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw[i]),
      .db_o    (db[i]),
      .press_o (press[i])
    );
  end

  logic unused_btn;
  assign unused_btn = ^{press[LED_W-1:2], db[0]};

  mode_e            mode_q, mode_d;
  mode_e            saved_q, saved_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_w;

  assign tick_w = (pre_q == PRE_LAST);

  // Priority: pause/resume, then mode advance (clears leds and prescaler), then pattern step.
  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    leds_d  = leds_q;
    pre_d   = tick_w ? '0 : pre_q + 1'b1;
    if (press[BTN_PAUSE]) begin
      if (mode_q == MODE_PAUSE) begin
        mode_d = saved_q;
      end else begin
        saved_d = mode_q;
        mode_d  = MODE_PAUSE;
      end
    end else if (press[BTN_NEXT] && (mode_q != MODE_PAUSE)) begin
      mode_d = next_mode(mode_q);
      leds_d = '0;
      pre_d  = '0;
    end else if (tick_w) begin
      case (mode_q)
        MODE_COUNT: leds_d = leds_q + 1'b1;
        MODE_SHIFT: leds_d = (leds_q == '0) ? {{(LED_W-1){1'b0}}, 1'b1}
                                            : {leds_q[LED_W-2:0], leds_q[LED_W-1]};
        MODE_XOR:   leds_d = {leds_q[LED_W-2:0] ^ db[LED_W-1:1], ~leds_q[0]};
        default:    leds_d = leds_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_COUNT;
      saved_q <= MODE_COUNT;
      leds_q  <= '0;
      pre_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      leds_q  <= leds_d;
      pre_q   <= pre_d;
    end
  end

  assign leds = leds_q;
  assign mode = mode_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer with a queue-based LED scoreboard.
module tb_led_mode_sequencer;

  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned DEBOUNCE = 4;
`ifdef LED_SEQ_SYNC_EN
  localparam int unsigned SYNC = 2;
`else
  localparam int unsigned SYNC = 0;
`endif
  localparam int unsigned LAT = DEBOUNCE + 1 + SYNC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       tick;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  led_mode_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .buttons (buttons),
    .leds    (leds),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      @(negedge clk);
      cyc++;
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mode(input logic [1:0] m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      step(1);
      if (mode === m) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [7:0] b);
    rst_n   = 1'b0;
    buttons = b;
    step(3);
    rst_n   = 1'b1;
  endtask

  task automatic test_reset;
    logic [1:0] em;
    rst_n   = 1'b0;
    buttons = 8'hFF;
    step(3);
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", leds); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    rst_n = 1'b1;
    for (int i = 1; i <= int'(LAT) + 1; i++) begin
      step(1);
      em = (i == int'(LAT) + 1) ? 2'd3 : 2'd0;
      checks++;
      if (mode !== em) begin
        errors++; $display("FAIL reset_release_press edge%0d: got mode %0d expected %0d", i, mode, em);
      end
    end
    buttons = 8'h00;
    step(DEBOUNCE + SYNC + 2);
  endtask

  task automatic test_count;
    bit ok; int cyc; logic [7:0] e;
    do_reset(8'h00);
    for (int t = 1; t <= 256; t++) begin
      wait_tick(ok, cyc);
      checks++;
      if (!ok) begin errors++; $display("FAIL count_tick_timeout: got none expected tick"); return; end
      if (t <= 5) begin
        checks++;
        if (cyc != int'(TICK_DIV) - 1) begin
          errors++; $display("FAIL count_tick_spacing: got %0d expected %0d", cyc, TICK_DIV - 1);
        end
      end
      exp_q.push_back(8'(t));
      step(1);
      e = exp_q.pop_front();
      checks++;
      if (leds !== e) begin errors++; $display("FAIL count_leds tick%0d: got %h expected %h", t, leds, e); end
    end
  endtask

  task automatic test_shift;
    bit ok; int cyc; logic [7:0] e;
    logic [7:0] tbl [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    do_reset(8'h00);
    buttons = 8'h01;
    wait_mode(2'd1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shift_enter: got mode %0d expected 1", mode); return; end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL shift_clear: got %h expected 00", leds); end
    for (int t = 0; t < 9; t++) begin
      if (tick !== 1'b1) wait_tick(ok, cyc); else ok = 1'b1;
      checks++;
      if (!ok) begin errors++; $display("FAIL shift_tick_timeout: got none expected tick"); return; end
      exp_q.push_back(tbl[t]);
      step(1);
      e = exp_q.pop_front();
      checks++;
      if (leds !== e || mode !== 2'd1) begin
        errors++; $display("FAIL shift_leds step%0d: got %h mode %0d expected %h mode 1", t, leds, mode, e);
      end
      buttons = 8'h00;
    end
  endtask

  task automatic test_glitch;
    bit changed; int n;
    do_reset(8'h00);
    buttons = 8'h01;
    step(DEBOUNCE - 1);
    buttons = 8'h00;
    changed = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (mode !== 2'd0) changed = 1'b1;
    end
    checks++; if (changed) begin errors++; $display("FAIL glitch_ignored: got mode %0d expected 0", mode); end
    buttons = 8'h01;
    n = 0;
    for (int i = 1; i <= int'(LAT) + 6; i++) begin
      step(1);
      if (mode !== 2'd0 && n == 0) n = i;
    end
    checks++;
    if (n != int'(LAT) + 1) begin errors++; $display("FAIL glitch_latency: got edge %0d expected %0d", n, LAT + 1); end
    buttons = 8'h00;
    step(DEBOUNCE + SYNC + 2);
  endtask

  task automatic test_pause;
    bit ok; int cyc; logic [7:0] e;
    do_reset(8'h00);
    for (int t = 1; t <= 2; t++) begin
      wait_tick(ok, cyc);
      exp_q.push_back(8'(t));
      step(1);
      e = exp_q.pop_front();
      checks++;
      if (!ok || leds !== e) begin errors++; $display("FAIL pause_pre_count: got %h expected %h", leds, e); end
    end
    step(7 - int'(LAT));
    buttons = 8'h02;
    wait_mode(2'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_enter: got mode %0d expected 3", mode); return; end
    checks++; if (leds !== 8'h03) begin errors++; $display("FAIL pause_leds_at_entry: got %h expected 03", leds); end
    buttons = 8'h00;
    for (int t = 0; t < 20; t++) begin
      if (t == 5) buttons = 8'h01;
      if (t == 8) buttons = 8'h00;
      wait_tick(ok, cyc);
      step(1);
      checks++;
      if (!ok || leds !== 8'h03 || mode !== 2'd3) begin
        errors++; $display("FAIL pause_hold tick%0d: got %h mode %0d expected 03 mode 3", t, leds, mode);
      end
    end
    buttons = 8'h02;
    wait_mode(2'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_resume: got mode %0d expected 0", mode); return; end
    checks++; if (leds !== 8'h03) begin errors++; $display("FAIL pause_resume_leds: got %h expected 03", leds); end
    buttons = 8'h00;
    if (tick !== 1'b1) wait_tick(ok, cyc); else ok = 1'b1;
    exp_q.push_back(8'h04);
    step(1);
    e = exp_q.pop_front();
    checks++; if (!ok || leds !== e) begin errors++; $display("FAIL pause_resume_step: got %h expected %h", leds, e); end
    step(DEBOUNCE + SYNC + 2);
    buttons = 8'h03;
    wait_mode(2'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL both_press: got mode %0d expected 3", mode); end
    step(4);
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL both_press_hold: got mode %0d expected 3", mode); end
    buttons = 8'h00;
    step(DEBOUNCE + SYNC + 2);
  endtask

  task automatic test_xor;
    bit ok; int cyc; logic [7:0] e; logic [7:0] base;
    logic [7:0] tbl [2][4] = '{'{8'h01, 8'h02, 8'h05, 8'h0A}, '{8'h05, 8'h0E, 8'h19, 8'h36}};
    for (int v = 0; v < 2; v++) begin
      base = (v == 0) ? 8'h00 : 8'h04;
      do_reset(base);
      step(LAT + 2);
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL xor_btn2_noeffect: got mode %0d expected 0", mode); end
      buttons = base | 8'h01;
      wait_mode(2'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL xor_first_press: got mode %0d expected 1", mode); end
      buttons = base;
      step(DEBOUNCE + SYNC + 2);
      buttons = base | 8'h01;
      wait_mode(2'd2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL xor_enter: got mode %0d expected 2", mode); return; end
      checks++; if (leds !== 8'h00) begin errors++; $display("FAIL xor_clear: got %h expected 00", leds); end
      buttons = base;
      for (int t = 0; t < 4; t++) begin
        if (tick !== 1'b1) wait_tick(ok, cyc); else ok = 1'b1;
        exp_q.push_back(tbl[v][t]);
        step(1);
        e = exp_q.pop_front();
        checks++;
        if (!ok || leds !== e) begin
          errors++; $display("FAIL xor_leds v%0d step%0d: got %h expected %h", v, t, leds, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_shift();
    test_glitch();
    test_pause();
    test_xor();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
